// File: rtl/and_arbiter_pkg.sv
// Shared definitions for the AND arbiter: FSM state encoding and default sizing.
package and_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [IW-1:0]    idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % N_REQ;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/and_arbiter.sv
// Round-robin arbiter that serves one requester at a time and returns the registered A & B result.
//  state | meaning
//  IDLE  | no transaction; arbitrate whenever any req is high
//  GRANT | gnt[winner] high; result computed from captured operands
//  DONE  | y_valid high; ptr advances; may arbitrate the next winner
module and_arbiter
  import and_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       y_out,
  output logic                   y_valid,
  output logic [IW-1:0]          y_id,
  output logic                   busy
);

  state_t           state, state_next;
  logic [IW-1:0]    ptr_q, ptr_eff, ptr_done;
  logic [IW-1:0]    winner_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] y_q;
  logic [IW-1:0]    y_id_q;
  logic             pick_any;
  logic [IW-1:0]    pick_idx;
  logic             load;

  assign ptr_done = IW'((int'(winner_q) + 1) % N_REQ);
  // DONE arbitrates with the already-advanced pointer so the just-served requester goes last.
  assign ptr_eff  = (state == DONE) ? ptr_done : ptr_q;
  assign load     = pick_any && (state == IDLE || state == DONE);

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr_eff),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = pick_any ? GRANT : IDLE;
      GRANT:   state_next = DONE;
      DONE:    state_next = pick_any ? GRANT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt     = '0;
    y_valid = 1'b0;
    busy    = 1'b0;
    case (state)
      GRANT: begin
        gnt[winner_q] = 1'b1;
        busy          = 1'b1;
      end
      DONE: begin
        y_valid = 1'b1;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      winner_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      y_id_q   <= '0;
    end else begin
      if (load) begin
        winner_q <= pick_idx;
        a_q      <= a_in[int'(pick_idx)*WIDTH +: WIDTH];
        b_q      <= b_in[int'(pick_idx)*WIDTH +: WIDTH];
      end
      if (state == GRANT) begin
        y_q    <= a_q & b_q;
        y_id_q <= winner_q;
      end
      if (state == DONE) ptr_q <= ptr_done;
    end
  end

  assign y_out = y_q;
  assign y_id  = y_id_q;

endmodule

// File: tb/tb_and_arbiter.sv
// Directed bench for and_arbiter: vector table of single transactions plus multi-cycle sequences.
module tb_and_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   y_out;
  logic           y_valid;
  logic [1:0]     y_id;
  logic           busy;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic seen1  = 1'b0;

  and_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .y_out(y_out), .y_valid(y_valid), .y_id(y_id), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mon_en && (gnt[1] || (y_valid && y_id == 2'd1))) seen1 = 1'b1;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [1:0]     id;
    logic [W-1:0]   y;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_gnt"},    32'(gnt),     32'h0);
    chk({name, "_valid"},  32'(y_valid), 32'h0);
    chk({name, "_busy"},   32'(busy),    32'h0);
  endtask

  initial begin
    vecs[0] = '{4'b0001, 32'h000000F0, 32'h0000003C, 2'd0, 8'h30};
    vecs[1] = '{4'b0100, 32'h00FF0000, 32'h000F0000, 2'd2, 8'h0F};
    vecs[2] = '{4'b1000, 32'hA5000000, 32'hFF000000, 2'd3, 8'hA5};
    vecs[3] = '{4'b0010, 32'h00001200, 32'h00003400, 2'd1, 8'h10};
    vecs[4] = '{4'b0011, 32'h0000EEC3, 32'h0000FF0F, 2'd0, 8'h03};
    vecs[5] = '{4'b0110, 32'h00FFFF00, 32'h00118100, 2'd1, 8'h81};
    vecs[6] = '{4'b1001, 32'h5A0000FF, 32'hF00000FF, 2'd3, 8'h50};
    vecs[7] = '{4'b1110, 32'h11220077, 32'hFFFFFFFF, 2'd1, 8'h00};

    // reset state
    #12;
    chk_idle_outputs("rst");
    chk("rst_yout", 32'(y_out), 32'h0);
    chk("rst_yid",  32'(y_id),  32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk_idle_outputs("post_rst");

    // table-driven single transactions; ptr carries across vectors
    for (int i = 0; i < 8; i++) begin
      req  = vecs[i].req;
      a_in = vecs[i].a;
      b_in = vecs[i].b;
      step();
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(4'b0001 << vecs[i].id));
      chk($sformatf("v%0d_gvalid", i), 32'(y_valid), 32'h0);
      req = '0;
      step();
      chk($sformatf("v%0d_valid", i), 32'(y_valid), 32'h1);
      chk($sformatf("v%0d_yout", i),  32'(y_out),   32'(vecs[i].y));
      chk($sformatf("v%0d_yid", i),   32'(y_id),    32'(vecs[i].id));
      chk($sformatf("v%0d_dgnt", i),  32'(gnt),     32'h0);
      a_in = ~a_in;
      step();
      chk_idle_outputs($sformatf("v%0d_idle", i));
      chk($sformatf("v%0d_hold", i), 32'(y_out), 32'(vecs[i].y));
    end

    // reset back to ptr=0, then fairness with all requests held
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst2");
    step();
    rst_n = 1'b1;
    a_in = 32'h40302010;
    b_in = 32'hFFFFFFFF;
    req  = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
      step();
      chk($sformatf("rr%0d_valid", k), 32'(y_valid), 32'h1);
      chk($sformatf("rr%0d_yid", k),   32'(y_id),    32'(k % 4));
      chk($sformatf("rr%0d_yout", k),  32'(y_out),   32'(8'h10 * (k % 4 + 1)));
    end
    req = '0;
    step();
    chk_idle_outputs("rr_end");

    // wrap-around: serve 2 (ptr->3), then 1001 gives 3 then 0
    a_in = 32'h0F0F0F0F;
    b_in = 32'hFFFFFFFF;
    req = 4'b0100;
    step(); chk("wr_g2", 32'(gnt), 32'h4);
    req = '0;
    step(); step();
    req = 4'b1001;
    step(); chk("wr_g3", 32'(gnt), 32'h8);
    req = 4'b0001;
    step(); chk("wr_id3", 32'(y_id), 32'd3);
    step(); chk("wr_g0", 32'(gnt), 32'h1);
    req = '0;
    step(); chk("wr_id0", 32'(y_id), 32'd0);
    step(); chk_idle_outputs("wr_end");

    // req1 pulsed during requester 0's GRANT is never served
    seen1  = 1'b0;
    mon_en = 1'b1;
    req = 4'b0001;
    step(); chk("wd_g0", 32'(gnt), 32'h1);
    req = 4'b0011;
    step(); chk("wd_id0", 32'(y_id), 32'd0);
    req = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_idle_outputs($sformatf("wd_idle%0d", k));
    end
    mon_en = 1'b0;
    chk("wd_never1", 32'(seen1), 32'h0);

    // reset during GRANT: ptr is 1 here, so without reset 1 would win
    req = 4'b1111;
    step(); chk("rg_g1", 32'(gnt), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("rg_gnt_async",  32'(gnt),  32'h0);
    chk("rg_busy_async", 32'(busy), 32'h0);
    @(negedge clk);
    chk_idle_outputs("rg_hold");
    step();
    chk("rg_valid", 32'(y_valid), 32'h0);
    rst_n = 1'b1;
    step(); chk("rg_g0", 32'(gnt), 32'h1);
    req = '0;
    step();
    chk("rg_id0", 32'(y_id), 32'd0);
    chk("rg_y0",  32'(y_out), 32'h0F);
    step();

    // operands captured at the arbitration edge
    a_in = 32'h00FF0000;
    b_in = 32'h00AA0000;
    req  = 4'b0100;
    step(); chk("cap_g2", 32'(gnt), 32'h4);
    a_in = 32'h00000000;
    req  = '0;
    step();
    chk("cap_yout", 32'(y_out), 32'hAA);
    chk("cap_yid",  32'(y_id),  32'd2);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/and_arbiter.md
AND_ARBITER -- requirements
Module: and_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the operand and result width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  N_REQ  SHALL carry per-requester request levels.
REQ-006 a_in  input  N_REQ*WIDTH  SHALL carry the flattened A operands; requester i at bits [i*WIDTH +: WIDTH].
REQ-007 b_in  input  N_REQ*WIDTH  SHALL carry the flattened B operands, packed the same way.
REQ-008 gnt  output  N_REQ  SHALL be a one-hot grant, or all-zero.
REQ-009 y_out  output  WIDTH  SHALL carry the registered result A & B of the served requester.
REQ-010 y_valid  output  1  SHALL pulse for one cycle when y_out and y_id are valid.
REQ-011 y_id  output  clog2(N_REQ)  SHALL carry the index of the requester that produced y_out.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT and DONE.
REQ-014 In IDLE with req != 0, the block SHALL pick a winner by round-robin starting at pointer ptr.
REQ-015 On that pick, the block SHALL latch the winner index and its a/b slices, then move to GRANT.
REQ-016 In IDLE with req == 0, the FSM SHALL stay in IDLE.
REQ-017 In GRANT, gnt[winner] SHALL be 1 for exactly that cycle.
REQ-018 In GRANT, y_out SHALL be loaded with a_q & b_q (bitwise, WIDTH bits), and the FSM SHALL move to DONE.
REQ-019 In DONE: y_valid=1, y_id=winner, and ptr SHALL update to (winner+1) mod N_REQ.
REQ-020 In DONE, arbitration SHALL use the updated ptr value combinationally.
REQ-021 In DONE with req != 0, the block SHALL latch a new winner and operands and go to GRANT; otherwise it SHALL go to IDLE.
REQ-022 Latency SHALL be: req sampled at edge T; gnt high in cycle T+1; y_valid high in cycle T+2.
REQ-023 Sustained throughput SHALL be one result per 2 cycles.
REQ-024 Requester handshake: hold req and operands until gnt is seen, then drop req.
REQ-025 Operands SHALL be captured at the arbitration edge; later operand changes SHALL NOT affect the result.
REQ-026 A req withdrawn before being picked SHALL NOT be served and SHALL NOT produce an error.
REQ-027 A req still high after its own gnt SHALL be treated as a new request, at lowest priority relative to ptr.
REQ-028 Fairness: with all req high, service order SHALL be ptr, ptr+1, …, wrapping from N_REQ-1 to 0.
REQ-029 gnt, y_valid and y_id SHALL never change outside the GRANT and DONE states.
REQ-030 y_out SHALL hold its last value between results.
REQ-031 Illegal state encodings SHALL return to IDLE on the next clock edge.

Reset
REQ-032 While rst_n=0, outputs SHALL be forced immediately: state=IDLE, ptr=0, gnt=0, y_valid=0, y_out=0, y_id=0, busy=0.
REQ-033 A reset mid-operation SHALL abandon the transaction with no y_valid pulse.
REQ-034 After reset release, the first arbitration SHALL occur at the first rising edge with rst_n=1 and req != 0.

Structure
REQ-035 Package and_arb_pkg SHALL hold the state typedef (IDLE/GRANT/DONE) and the default N_REQ/WIDTH constants.
REQ-036 Sub-module rr_pick SHALL be purely combinational.
REQ-037 rr_pick inputs SHALL be req and ptr; its outputs SHALL be any (1 bit) and idx (clog2 N_REQ bits).
REQ-038 rr_pick SHALL be instantiated once.

Verification
REQ-039 Reset, then req=4'b0001, a0=8'hF0, b0=8'h3C -> gnt=0001 in T+1; y_valid in T+2 with y_out=8'h30, y_id=0.
REQ-040 req=4'b1111 held continuously, every requester dropping/reasserting per handshake -> y_id sequence 0,1,2,3,0,1 with results 2 cycles apart.
REQ-041 ptr=3 (after serving req2), then req=4'b1001 -> requester 3 served first, then requester 0 (wrap-around).
REQ-042 req1 pulsed for 1 cycle while requester 0 is in GRANT -> requester 1 never granted and no y_id=1 result.
REQ-043 rst_n asserted during GRANT -> gnt and busy fall asynchronously, no y_valid, and the next request is arbitrated from ptr=0.
REQ-044 a2 changed from 8'hFF to 8'h00 in the GRANT cycle with b2=8'hAA -> y_out=8'hAA (captured operands used).
